mem_io_bridge: RTL and testbench
================================

// Module: mem_io_bridge
// PURPOSE
//  Data-side bus bridge between mips_core's memory port and data_ram. Decodes each access:
//  the IO window goes to a local peripheral block (interval timer, status, GPIO out);
//  every other address goes to data_ram. The timer drives the core's ir_in interrupt input.
//  Both paths return read data with the same 1-cycle latency as the synchronous data_ram.
// PARAMETERS
//  IO_BASE    32'hFFFF_0000  base of 64 KB IO window; io_sel = (cpu_addr[31:16] == IO_BASE[31:16])
//  RAM_AW     32             width of ram_addr; ram_addr = {2'b0, cpu_addr[31:2]} truncated to RAM_AW
//  TIMER_W    32             timer counter/load width (<=32, zero-extended on read)
// PORTS
//  clk        in   1       main clock
//  rst        in   1       synchronous reset, active-high
//  cpu_ren    in   1       core read strobe
//  cpu_wen    in   1       core write strobe
//  cpu_addr   in   32      byte address, word-aligned; [1:0] ignored
//  cpu_wdata  in   32      core write data
//  cpu_rdata  out  32      read data, valid the cycle after cpu_ren
//  ram_we     out  1       data_ram write enable
//  ram_addr   out  RAM_AW  data_ram word address
//  ram_din    out  32      data_ram write data (= cpu_wdata)
//  ram_dout   in   32      data_ram read data (1-cycle synchronous)
//  gpio_out   out  32      GPIO output register
//  irq        out  1       interrupt to core ir_in, level, = pending & ctrl.ie
// BEHAVIOUR
//  Reset: all registers 0; cpu_rdata=0, irq=0, gpio_out=0, ram_we=0. Timer disabled.
//  RAM path (io_sel=0): ram_we = cpu_wen; ram_addr and ram_din are combinational pass-through.
//  IO path (io_sel=1): ram_we=0; writes apply at the clock edge; reads latch register value
//  into io_rdata at the edge. sel_q <= io_sel & cpu_ren at each edge; cpu_rdata = sel_q ? io_rdata : ram_dout.
//  Cycle N: cpu_ren + addr; cycle N+1: cpu_rdata valid. Without cpu_ren, io_rdata holds and sel_q clears.
//  IO register map (offset = cpu_addr[15:0]):
//   0x00 CTRL   RW  [0]=en [1]=auto_reload [2]=ie; other bits read 0
//   0x04 LOAD   RW  reload value; a write also sets COUNT=wdata in the same edge
//   0x08 COUNT  RO  current count; writes ignored
//   0x0C STATUS RW1C [0]=pending; writing 1 to bit0 clears it, writing 0 has no effect
//   0x10 GPIO   RW  gpio_out
//   Other offsets: read 0, writes ignored.
//  Timer, per cycle with en=1: COUNT!=0 -> COUNT-1. COUNT==0 -> pending<=1 and
//   auto_reload=1: COUNT<=LOAD, en stays 1; auto_reload=0: en<=0, COUNT stays 0.
//   With en=0, COUNT holds.
//  Simultaneous events:
//   - expiry + STATUS W1C in the same cycle -> pending=1 (set wins)
//   - LOAD write + decrement -> COUNT=written value
//   - CTRL write + expiry -> the CTRL write value wins for en; pending still sets
//  Read of IO register in the cycle it is written returns the pre-write value.
//  cpu_ren and cpu_wen both high: write and read both performed; read returns the old value.
//  rst mid-operation: everything returns to reset values on that edge; irq drops the next cycle.
//  irq is combinational from registered state: no combinational path from cpu_* to irq.
// TESTING
//  1 RAM: write 0xDEADBEEF to 0x0000_0040, then read -> ram_we=1 and ram_addr=0x10
//    in the write cycle; cpu_rdata=0xDEADBEEF one cycle after cpu_ren; gpio_out unchanged.
//  2 IO isolation: write 0x1234 to 0xFFFF_0010 -> ram_we=0, gpio_out=0x1234;
//    read 0xFFFF_0010 -> 0x1234; read 0xFFFF_0020 -> 0.
//  3 One-shot: LOAD=3, CTRL=0x5 -> COUNT reads 3,2,1,0 on successive cycles;
//    pending=1 and irq=1 on the expiry edge, en then reads 0; W1C STATUS -> irq=0 next cycle.
//  4 Auto-reload: LOAD=2, CTRL=0x7 -> pending set every 3 cycles and COUNT reloads to 2;
//    W1C on an expiry cycle -> pending stays 1.
//  5 Reset mid-count: rst=1 with COUNT=5 and irq=1 -> next cycle COUNT=0, CTRL=0,
//    irq=0, gpio_out=0, cpu_rdata=0.
//  6 Back-to-back reads RAM then IO then RAM -> cpu_rdata mux follows sel_q each cycle
//    with no stale data.

Source files
------------

// File: rtl/mem_io_bridge.sv
// Data-side bridge between the core memory port and data_ram, with a local IO block
// (interval timer, status, GPIO) decoded in a 64 KB window. Both paths return data one cycle after cpu_ren.
module mem_io_bridge #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int          RAM_AW  = 32,
  parameter int          TIMER_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [31:0]       gpio_out,
  output logic              irq
);

  typedef enum logic [13:0] {
    REG_CTRL   = 14'd0,
    REG_LOAD   = 14'd1,
    REG_COUNT  = 14'd2,
    REG_STATUS = 14'd3,
    REG_GPIO   = 14'd4
  } reg_e;

  logic               io_sel;
  logic [31:0]        word_addr;
  logic [13:0]        word_off;
  logic               io_rd, io_wr;
  logic               wr_ctrl, wr_load, wr_status, wr_gpio;
  logic               expire;
  logic [31:0]        rd_val;

  logic               ctrl_en, ctrl_ar, ctrl_ie;
  logic               pending;
  logic [TIMER_W-1:0] load_q, count_q;
  logic [31:0]        gpio_q;
  logic [31:0]        io_rdata;
  logic               sel_q, ram_q;

  assign io_sel    = (cpu_addr[31:16] == IO_BASE[31:16]);
  assign word_addr = {2'b00, cpu_addr[31:2]};
  assign word_off  = cpu_addr[15:2];

  assign ram_addr  = word_addr[RAM_AW-1:0];
  assign ram_din   = cpu_wdata;
  assign ram_we    = cpu_wen & ~io_sel & ~rst;

  assign io_rd     = cpu_ren & io_sel;
  assign io_wr     = cpu_wen & io_sel;
  assign wr_ctrl   = io_wr && (word_off == REG_CTRL);
  assign wr_load   = io_wr && (word_off == REG_LOAD);
  assign wr_status = io_wr && (word_off == REG_STATUS);
  assign wr_gpio   = io_wr && (word_off == REG_GPIO);

  assign expire    = ctrl_en && (count_q == '0);

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    rd_val = '0;
    case (word_off)
      REG_CTRL:   rd_val = {29'b0, ctrl_ie, ctrl_ar, ctrl_en};
      REG_LOAD:   rd_val = 32'(load_q);
      REG_COUNT:  rd_val = 32'(count_q);
      REG_STATUS: rd_val = {31'b0, pending};
      REG_GPIO:   rd_val = gpio_q;
      default:    rd_val = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears every register; there is no memory array to leave unreset.
    if (rst) begin
      ctrl_en  <= 1'b0;
      ctrl_ar  <= 1'b0;
      ctrl_ie  <= 1'b0;
      pending  <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
      gpio_q   <= '0;
      io_rdata <= '0;
      sel_q    <= 1'b0;
      ram_q    <= 1'b0;
    end else begin
      sel_q <= io_rd;
      ram_q <= cpu_ren & ~io_sel;
      if (io_rd) io_rdata <= rd_val;

      // A CTRL write overrides the one-shot auto-disable on expiry.
      if (wr_ctrl) begin
        ctrl_en <= cpu_wdata[0];
        ctrl_ar <= cpu_wdata[1];
        ctrl_ie <= cpu_wdata[2];
      end else if (expire && !ctrl_ar) begin
        ctrl_en <= 1'b0;
      end

      if (wr_load) load_q <= cpu_wdata[TIMER_W-1:0];

      if (wr_load)                 count_q <= cpu_wdata[TIMER_W-1:0];
      else if (expire && ctrl_ar)  count_q <= load_q;
      else if (ctrl_en && !expire) count_q <= count_q - TIMER_W'(1);

      // Expiry beats a simultaneous W1C so no interrupt is lost.
      if (expire)                          pending <= 1'b1;
      else if (wr_status && cpu_wdata[0])  pending <= 1'b0;

      if (wr_gpio) gpio_q <= cpu_wdata;
    end
  end

  assign gpio_out  = gpio_q;
  assign irq       = pending & ctrl_ie;
  assign cpu_rdata = sel_q ? io_rdata : (ram_q ? ram_dout : 32'h0);

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model of the bridge and data_ram.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        rst, cpu_ren, cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_din, ram_dout, gpio_out;
  logic        irq;

  always #5 clk = ~clk;

  mem_io_bridge dut (
    .clk(clk), .rst(rst), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .gpio_out(gpio_out), .irq(irq)
  );

  // Synchronous data_ram stand-in (read-before-write).
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr[7:0]] <= ram_din;
    ram_dout <= ram_mem[ram_addr[7:0]];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model state
  bit          m_en, m_ar, m_ie, m_pend, m_rvalid;
  logic [31:0] m_load, m_count, m_gpio, m_rdata;
  logic [31:0] m_mem [256];

  function automatic logic [31:0] m_reg_read(input logic [15:0] off);
    case (off & 16'hFFFC)
      16'h0000: return {29'b0, m_ie, m_ar, m_en};
      16'h0004: return m_load;
      16'h0008: return m_count;
      16'h000C: return {31'b0, m_pend};
      16'h0010: return m_gpio;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d);
    bit io, expire;
    logic [15:0] off;
    if (r) begin
      {m_en, m_ar, m_ie, m_pend} = '0;
      m_load = 0; m_count = 0; m_gpio = 0;
      m_rvalid = 1; m_rdata = 0;
      return;
    end
    io  = (a[31:16] == 16'hFFFF);
    off = a[15:0] & 16'hFFFC;
    m_rvalid = rd;
    if (rd) m_rdata = io ? m_reg_read(a[15:0]) : m_mem[a[9:2]];
    expire = m_en && (m_count == 0);
    // timer advance
    if (expire) begin
      if (m_ar) m_count = m_load;
      else      m_en = 0;
    end else if (m_en) begin
      m_count = m_count - 1;
    end
    // register writes take precedence over the timer
    if (wr && io) begin
      case (off)
        16'h0000: begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
        16'h0004: begin m_load = d; m_count = d; end
        16'h000C: if (d[0]) m_pend = 0;
        16'h0010: m_gpio = d;
        default: ;
      endcase
    end
    if (expire) m_pend = 1;
    if (wr && !io) m_mem[a[9:2]] = d;
  endtask

  task automatic cycle(input bit r, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    bit io;
    rst = r; cpu_ren = rd; cpu_wen = wr; cpu_addr = a; cpu_wdata = d;
    #2;
    io = (a[31:16] == 16'hFFFF);
    check("ram_we", 32'(ram_we), 32'(wr & ~io & ~r));
    check("ram_addr", ram_addr, a >> 2);
    check("ram_din", ram_din, d);
    model_step(r, rd, wr, a, d);
    @(posedge clk); #1;
    if (m_rvalid) check("cpu_rdata", cpu_rdata, m_rdata);
    check("irq", 32'(irq), 32'(m_pend & m_ie));
    check("gpio_out", gpio_out, m_gpio);
  endtask

  typedef struct {
    bit          ren, wen;
    logic [31:0] addr, wdata;
    bit          exp_we;
    logic [31:0] exp_raddr;
    bit          chk_rd;
    logic [31:0] exp_rdata;
    bit          exp_irq;
    logic [31:0] exp_gpio;
  } vec_t;

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 256; i++) begin ram_mem[i] = 0; m_mem[i] = 0; end
    rst = 1; cpu_ren = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;

    //           ren wen addr           wdata        we raddr          chk rdata        irq gpio
    tbl[0]  = '{0, 1, 32'h0000_0040, 32'hDEADBEEF, 1, 32'h0000_0010, 0, 32'h0,        0, 32'h0};
    tbl[1]  = '{1, 0, 32'h0000_0040, 32'h0,        0, 32'h0000_0010, 1, 32'hDEADBEEF, 0, 32'h0};
    tbl[2]  = '{0, 1, 32'hFFFF_0010, 32'h1234,     0, 32'h3FFF_C004, 0, 32'h0,        0, 32'h1234};
    tbl[3]  = '{1, 0, 32'hFFFF_0010, 32'h0,        0, 32'h3FFF_C004, 1, 32'h1234,     0, 32'h1234};
    tbl[4]  = '{1, 0, 32'hFFFF_0020, 32'h0,        0, 32'h3FFF_C008, 1, 32'h0,        0, 32'h1234};
    tbl[5]  = '{0, 1, 32'hFFFF_0004, 32'h3,        0, 32'h3FFF_C001, 0, 32'h0,        0, 32'h1234};
    tbl[6]  = '{0, 1, 32'hFFFF_0000, 32'h5,        0, 32'h3FFF_C000, 0, 32'h0,        0, 32'h1234};
    tbl[7]  = '{1, 0, 32'hFFFF_0008, 32'h0,        0, 32'h3FFF_C002, 1, 32'h3,        0, 32'h1234};
    tbl[8]  = '{1, 0, 32'hFFFF_0008, 32'h0,        0, 32'h3FFF_C002, 1, 32'h2,        0, 32'h1234};
    tbl[9]  = '{1, 0, 32'hFFFF_0008, 32'h0,        0, 32'h3FFF_C002, 1, 32'h1,        0, 32'h1234};
    tbl[10] = '{1, 0, 32'hFFFF_0008, 32'h0,        0, 32'h3FFF_C002, 1, 32'h0,        1, 32'h1234};
    tbl[11] = '{1, 0, 32'hFFFF_0000, 32'h0,        0, 32'h3FFF_C000, 1, 32'h4,        1, 32'h1234};
    tbl[12] = '{1, 0, 32'hFFFF_000C, 32'h0,        0, 32'h3FFF_C003, 1, 32'h1,        1, 32'h1234};
    tbl[13] = '{0, 1, 32'hFFFF_000C, 32'h1,        0, 32'h3FFF_C003, 0, 32'h0,        0, 32'h1234};
    tbl[14] = '{1, 0, 32'hFFFF_000C, 32'h0,        0, 32'h3FFF_C003, 1, 32'h0,        0, 32'h1234};

    @(posedge clk); #1;
    cycle(1, 0, 0, 32'h0, 32'h0);
    cycle(1, 0, 0, 32'h0, 32'h0);
    check("reset_cpu_rdata", cpu_rdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_gpio", gpio_out, 32'h0);

    // Directed table: RAM path, IO isolation, one-shot timer
    for (int i = 0; i < 15; i++) begin
      rst = 0; cpu_ren = tbl[i].ren; cpu_wen = tbl[i].wen;
      cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      #1;
      check($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(tbl[i].exp_we));
      check($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].exp_raddr);
      cycle(0, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), cpu_rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
      check($sformatf("tbl%0d_gpio", i), gpio_out, tbl[i].exp_gpio);
    end

    // Auto-reload: expiry every third cycle, W1C on an expiry cycle loses to the set
    cycle(0, 0, 1, 32'hFFFF_0004, 32'h2);
    cycle(0, 0, 1, 32'hFFFF_0000, 32'h7);
    cycle(0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0);
    check("ar_before_expiry_irq", 32'(irq), 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0);
    check("ar_expiry_irq", 32'(irq), 32'h1);
    cycle(0, 0, 1, 32'hFFFF_000C, 32'h1);
    check("ar_w1c_irq", 32'(irq), 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0);
    cycle(0, 0, 1, 32'hFFFF_000C, 32'h1);
    check("ar_w1c_on_expiry_irq", 32'(irq), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
    check("ar_reload_count", cpu_rdata, 32'h2);

    // Reset in the middle of a count with irq asserted
    cycle(0, 0, 1, 32'hFFFF_0004, 32'h5);
    check("pre_reset_irq", 32'(irq), 32'h1);
    cycle(1, 1, 0, 32'hFFFF_0008, 32'h0);
    check("post_reset_irq", 32'(irq), 32'h0);
    check("post_reset_gpio", gpio_out, 32'h0);
    check("post_reset_rdata", cpu_rdata, 32'h0);
    cycle(0, 1, 0, 32'hFFFF_0008, 32'h0);
    check("post_reset_count", cpu_rdata, 32'h0);
    cycle(0, 1, 0, 32'hFFFF_0000, 32'h0);
    check("post_reset_ctrl", cpu_rdata, 32'h0);

    // Back-to-back reads RAM / IO / RAM, and read+write on one register
    cycle(0, 0, 1, 32'h0000_0080, 32'hA5A5_A5A5);
    cycle(0, 0, 1, 32'hFFFF_0010, 32'h77);
    cycle(0, 1, 0, 32'h0000_0080, 32'h0);
    check("b2b_ram0", cpu_rdata, 32'hA5A5_A5A5);
    cycle(0, 1, 0, 32'hFFFF_0010, 32'h0);
    check("b2b_io", cpu_rdata, 32'h77);
    cycle(0, 1, 0, 32'h0000_0040, 32'h0);
    check("b2b_ram1", cpu_rdata, 32'hDEADBEEF);
    cycle(0, 1, 1, 32'hFFFF_0010, 32'h99);
    check("rw_same_cycle_old", cpu_rdata, 32'h77);
    check("rw_same_cycle_gpio", gpio_out, 32'h99);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, rd, wr;
      logic [31:0] a, d;
      r  = ($urandom_range(0, 199) == 0);
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 4) a = 32'($urandom_range(0, 255)) << 2;
      else                          a = 32'hFFFF_0000 | (32'($urandom_range(0, 6)) << 2);
      a = a | 32'($urandom_range(0, 3));
      d = $urandom;
      if (a[31:16] == 16'hFFFF && a[15:2] == 14'd1) d = 32'($urandom_range(0, 6));
      if (a[31:16] == 16'hFFFF && a[15:2] == 14'd0) d = 32'($urandom_range(0, 7));
      cycle(r, rd, wr, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
